// File: rtl/ibex_instr_mem_responder_pkg.sv
// Shared types for the instruction-fetch responder: per-grant response queue entry and constants.
package ibex_instr_mem_responder_pkg;

  localparam int unsigned IMEM_IDX_W = 30;
  localparam int unsigned IMEM_CNT_W = 8;
  localparam logic [31:0] IMEM_ERR_RDATA = 32'h0;

  typedef struct packed {
    logic [IMEM_IDX_W-1:0] idx;
    logic                  err;
    logic [IMEM_CNT_W-1:0] cnt;
  } imem_resp_entry_t;

endpackage

// File: rtl/ibex_instr_mem_resp_queue.sv
// In-order response FIFO; every slot counts down its latency, and the head is ready once its count reaches zero.
module ibex_instr_mem_resp_queue
  import ibex_instr_mem_responder_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  imem_resp_entry_t push_entry,
  input  logic             pop,
  output imem_resp_entry_t head,
  output logic             head_ready,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  imem_resp_entry_t slots [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Free slots also count down harmlessly; a push overwrites the whole entry.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Depth; i++) begin
      if (slots[i].cnt != '0) slots[i].cnt <= slots[i].cnt - 1'b1;
    end
    if (push) slots[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  assign head       = slots[rd_ptr];
  assign head_ready = (count != '0) && (head.cnt == '0);

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch bus responder: grants fetches under back-pressure and answers in order after a
// fixed latency from a word array with a separate load port.
module ibex_instr_mem_responder
  import ibex_instr_mem_responder_pkg::*;
#(
  parameter  int unsigned MemWords       = 1024,
  parameter  logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter  int unsigned MaxOutstanding = 2,
  parameter  int unsigned RespLatency    = 1,
  localparam int unsigned AW             = (MemWords > 1) ? $clog2(MemWords) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          stall_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic [31:0]   mem_wdata_i,
  output logic          busy_o
);

  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
  localparam logic [32:0] LoAddr = {1'b0, BaseAddr};
  localparam logic [32:0] HiAddr = LoAddr + (33'(MemWords) << 2);

  logic [31:0]      mem [MemWords];
  logic [CntW-1:0]  outstanding;
  imem_resp_entry_t push_entry, head;
  logic             head_ready, pop, addr_err;
  logic [31:0]      offset;
  logic             unused_bits;

  always_ff @(posedge clk_i) begin
    if (mem_we_i) mem[mem_waddr_i] <= mem_wdata_i;
  end

  // 33-bit compare so the top of a memory ending at 2^32 does not wrap.
  assign offset   = instr_addr_i - BaseAddr;
  assign addr_err = (instr_addr_i[1:0] != 2'b00) |
                    ({1'b0, instr_addr_i} < LoAddr) |
                    ({1'b0, instr_addr_i} >= HiAddr);

  assign instr_gnt_o = instr_req_i & ~stall_i & ~rst_i &
                       (outstanding < CntW'(MaxOutstanding));

  always_comb begin
    push_entry     = '0;
    push_entry.idx = offset[31:2];
    push_entry.err = addr_err;
    push_entry.cnt = IMEM_CNT_W'(RespLatency - 1);
  end

  ibex_instr_mem_resp_queue #(
    .Depth(MaxOutstanding)
  ) u_queue (
    .clk_i,
    .rst_i,
    .push       (instr_gnt_o),
    .push_entry,
    .pop,
    .head,
    .head_ready,
    .count      (outstanding)
  );

  assign pop            = head_ready & ~rst_i;
  assign instr_rvalid_o = pop;
  assign instr_err_o    = pop & head.err;
  assign busy_o         = (outstanding != '0) & ~rst_i;

  // Array is read in the response cycle, so a same-cycle load-port write returns old data.
  always_comb begin
    instr_rdata_o = '0;
    if (pop) instr_rdata_o = head.err ? IMEM_ERR_RDATA : mem[head.idx[AW-1:0]];
  end

  assign unused_bits = ^{offset[1:0], head.idx};

`ifndef SYNTHESIS
  a_params: assert property (@(posedge clk_i)
    (MaxOutstanding >= 1) && (RespLatency >= 1) && (RespLatency <= (1 << IMEM_CNT_W)) &&
    ((33'(BaseAddr) % (33'(MemWords) << 2)) == 33'd0));
  a_err_valid: assert property (@(posedge clk_i) instr_err_o |-> instr_rvalid_o);
  a_max_out: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding <= CntW'(MaxOutstanding));
  a_rv_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_o |-> (outstanding != '0));
  a_addr_known: assert property (@(posedge clk_i) disable iff (rst_i)
    instr_req_i |-> !$isunknown(instr_addr_i));
`endif

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench for two responders (latency 1 and latency 3): directed table and sequences plus randomized
// traffic, all checked every cycle against a due-cycle queue model.
module tb_ibex_instr_mem_responder;

  localparam int unsigned LAT  [2] = '{1, 3};
  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [2], stall [2], we [2];
  logic [31:0] addr [2], wdata [2];
  logic [9:0]  waddr [2];
  logic        gnt [2], rvalid [2], err [2], busy [2];
  logic [31:0] rdata [2];

  always #5 clk = ~clk;

  ibex_instr_mem_responder u_dut0 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
    .instr_err_o(err[0]), .stall_i(stall[0]), .mem_we_i(we[0]), .mem_waddr_i(waddr[0]),
    .mem_wdata_i(wdata[0]), .busy_o(busy[0])
  );

  ibex_instr_mem_responder #(.MaxOutstanding(2), .RespLatency(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
    .instr_err_o(err[1]), .stall_i(stall[1]), .mem_we_i(we[1]), .mem_waddr_i(waddr[1]),
    .mem_wdata_i(wdata[1]), .busy_o(busy[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  // Reference model: each grant becomes a pending response due at grant cycle + latency.
  typedef struct { int unsigned due; int unsigned idx; bit err; } pend_t;
  pend_t       pq [2][$];
  logic [31:0] mmem [2][1024];
  int unsigned cyc = 0;
  bit          eg, ev, ee;
  logic [31:0] ed;
  pend_t       p;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      eg = req[d] && !stall[d] && !rst && (pq[d].size() < MAXO);
      ev = 0; ee = 0; ed = '0;
      if (!rst && pq[d].size() > 0 && pq[d][0].due == cyc) begin
        ev = 1;
        ee = pq[d][0].err;
        ed = ee ? 32'h0 : mmem[d][pq[d][0].idx];
      end
      check("m_gnt", d, gnt[d], eg);
      check("m_rvalid", d, rvalid[d], ev);
      check("m_rdata", d, rdata[d], ed);
      check("m_err", d, err[d], ee);
      check("m_busy", d, busy[d], !rst && pq[d].size() != 0);
      if (rst) pq[d].delete();
      else begin
        if (ev) void'(pq[d].pop_front());
        if (eg) begin
          p.due = cyc + LAT[d];
          p.idx = addr[d][11:2];
          p.err = (addr[d][1:0] != 2'b00) || (addr[d] >= 32'h1000);
          pq[d].push_back(p);
        end
      end
      if (we[d]) mmem[d][waddr[d]] = wdata[d];
    end
    cyc++;
  end

  typedef struct { logic [31:0] addr; logic err; logic [31:0] data; } vec_t;
  vec_t        tbl [7];
  logic [9:0]  gbits, vbits;
  logic [31:0] dat [10];
  int          k;
  logic [31:0] v;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; stall[d] = 0; we[d] = 0; addr[d] = '0; waddr[d] = '0; wdata[d] = '0;
    end
    tick(); tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_rvalid", d, rvalid[d], 0);
      check("rst_busy", d, busy[d], 0);
      check("rst_rdata", d, rdata[d], 0);
    end
    tick(); rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("post_rst_gnt", d, gnt[d], 0);
      check("post_rst_rvalid", d, rvalid[d], 0);
      check("post_rst_err", d, err[d], 0);
    end

    // Preload both arrays identically through the load port.
    for (int i = 0; i < 1024; i++) begin
      tick();
      v = (i == 3) ? 32'h0011_2233 : (i < 8) ? (32'h1000_0000 + i) :
          (i == 1023) ? 32'hDEAD_BEEF : $urandom;
      for (int d = 0; d < 2; d++) begin we[d] = 1; waddr[d] = 10'(i); wdata[d] = v; end
    end
    tick();
    for (int d = 0; d < 2; d++) we[d] = 0;

    // Single fetches on the latency-1 instance.
    tbl[0] = '{32'h0000_000C, 1'b0, 32'h0011_2233};
    tbl[1] = '{32'h0000_0002, 1'b1, 32'h0};
    tbl[2] = '{32'h0000_1000, 1'b1, 32'h0};
    tbl[3] = '{32'h0000_0FFC, 1'b0, 32'hDEAD_BEEF};
    tbl[4] = '{32'h0000_0004, 1'b0, 32'h1000_0001};
    tbl[5] = '{32'hFFFF_FFFC, 1'b1, 32'h0};
    tbl[6] = '{32'h0000_001C, 1'b0, 32'h1000_0007};
    for (int i = 0; i < 7; i++) begin
      tick(); req[0] = 1; addr[0] = tbl[i].addr;
      @(negedge clk);
      check("tbl_gnt", 0, gnt[0], 1);
      check("tbl_no_early_rvalid", 0, rvalid[0], 0);
      tick(); req[0] = 0;
      @(negedge clk);
      check("tbl_rvalid", 0, rvalid[0], 1);
      check("tbl_rdata", 0, rdata[0], tbl[i].data);
      check("tbl_err", 0, err[0], tbl[i].err);
    end

    // Back-to-back on the latency-3 instance; a retiring response does not free a slot that cycle.
    tick(); req[1] = 1; addr[1] = 32'h0; k = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      gbits[t] = gnt[1]; vbits[t] = rvalid[1]; dat[t] = rdata[1];
      if (gnt[1]) k++;
      tick();
      if (k < 3) addr[1] = 32'(k * 4); else req[1] = 0;
    end
    check("b2b_gnt_pattern", 1, 32'(gbits), 32'b00_0001_0011);
    check("b2b_rvalid_pattern", 1, 32'(vbits), 32'b00_1001_1000);
    check("b2b_rdata0", 1, dat[3], 32'h1000_0000);
    check("b2b_rdata1", 1, dat[4], 32'h1000_0001);
    check("b2b_rdata2", 1, dat[7], 32'h1000_0002);

    // Stall with request held.
    stall[1] = 1; req[1] = 1; addr[1] = 32'h8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_gnt", 1, gnt[1], 0);
      check("stall_busy", 1, busy[1], 0);
      check("stall_rvalid", 1, rvalid[1], 0);
      tick();
    end
    stall[1] = 0;
    @(negedge clk);
    check("stall_release_gnt", 1, gnt[1], 1);
    tick(); req[1] = 0;
    repeat (4) tick();

    // Load-port write colliding with the response cycle.
    req[0] = 1; addr[0] = 32'h0;
    @(negedge clk);
    check("coll_gnt", 0, gnt[0], 1);
    tick(); req[0] = 0; we[0] = 1; waddr[0] = 10'd0; wdata[0] = 32'hB0B0_B0B0;
    @(negedge clk);
    check("coll_old_data", 0, rdata[0], 32'h1000_0000);
    tick(); we[0] = 0; req[0] = 1; addr[0] = 32'h0;
    tick(); req[0] = 0;
    @(negedge clk);
    check("coll_new_data", 0, rdata[0], 32'hB0B0_B0B0);

    // Reset with two responses in flight on the latency-3 instance.
    tick(); req[1] = 1; addr[1] = 32'h10;
    @(negedge clk);
    check("rst_mid_gnt0", 1, gnt[1], 1);
    tick(); addr[1] = 32'h14;
    @(negedge clk);
    check("rst_mid_gnt1", 1, gnt[1], 1);
    tick(); req[1] = 0; rst = 1;
    tick(); rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_mid_no_rvalid", 1, rvalid[1], 0);
      check("rst_mid_busy", 1, busy[1], 0);
      tick();
    end
    req[1] = 1; addr[1] = 32'h14;
    @(negedge clk);
    check("rst_after_gnt", 1, gnt[1], 1);
    tick(); req[1] = 0;
    tick(); tick();
    @(negedge clk);
    check("rst_after_rvalid", 1, rvalid[1], 1);
    check("rst_after_rdata", 1, rdata[1], 32'h1000_0005);

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      for (int d = 0; d < 2; d++) begin
        req[d]   = ($urandom_range(0, 3) != 0);
        stall[d] = ($urandom_range(0, 4) == 0);
        we[d]    = ($urandom_range(0, 4) == 0);
        waddr[d] = 10'($urandom_range(0, 1023));
        wdata[d] = $urandom;
        case ($urandom_range(0, 9))
          7:       addr[d] = $urandom;
          8:       addr[d] = 32'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3));
          9:       addr[d] = 32'h1000 + 32'($urandom_range(0, 3) * 4);
          default: addr[d] = 32'($urandom_range(0, 1023) * 4);
        endcase
      end
    end
    tick(); rst = 0;
    for (int d = 0; d < 2; d++) begin req[d] = 0; we[d] = 0; stall[d] = 0; end
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
